// File: rtl/router_pkt_reader.sv
// router_pkt_reader
// Pulls bytes one at a time from router_fifo and forwards each one downstream
// on a valid/ready interface. Bytes are tagged as header (sop) or parity (eop),
// and each packet's parity and length are checked.
// Packet: header {len[5:0], addr[1:0]}, len payload bytes, one parity byte
// (XOR of the header and all payload bytes).
//
// Ports
//   clk            single clock, rising edge
//   resetn         asynchronous active-low reset
//   fifo_empty     router_fifo empty flag
//   fifo_data      router_fifo read data, valid the cycle after fifo_read_enb
//   fifo_read_enb  read strobe to router_fifo (combinational)
//   dout           forwarded byte
//   dout_valid     dout holds a byte; transfer = dout_valid & dout_ready
//   dout_ready     downstream accepts
//   dout_sop       dout is a header byte
//   dout_eop       dout is a parity byte
//   dout_err       with dout_eop: parity mismatch or length above MAX_LEN
//   err_cnt        saturating count of accepted errored packets
//                  (present only when ROUTER_PKT_READER_ERR_CNT_EN is defined)
//   busy           packet in progress, read outstanding or byte held
//
// Optional feature macro: ROUTER_PKT_READER_ERR_CNT_EN
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | next captured byte is a header
// ST_PAYLOAD | capturing payload bytes, remaining_q still to come
// ST_PARITY  | next captured byte is the parity byte

module router_pkt_reader #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enb,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_err,
`ifdef ROUTER_PKT_READER_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_PARITY
    } state_t;

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    state_t     state_q, state_d;
    logic       pending_q;
    logic [5:0] remaining_q, remaining_d;
    logic [7:0] acc_q, acc_d;
    logic       len_err_q, len_err_d;
    logic [7:0] dout_q;
    logic       dout_valid_q, dout_sop_q, dout_eop_q, dout_err_q;
    logic       cap_sop, cap_eop, cap_err;

    // A new read is only issued when the output register will be free by the
    // time the data arrives, so at most one byte is ever in flight.
    assign fifo_read_enb = resetn & ~fifo_empty & ~pending_q
                         & (~dout_valid_q | dout_ready);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        len_err_d   = len_err_q;
        cap_sop     = 1'b0;
        cap_eop     = 1'b0;
        cap_err     = 1'b0;
        if (pending_q) begin
            case (state_q)
                ST_IDLE: begin
                    cap_sop     = 1'b1;
                    acc_d       = fifo_data;
                    remaining_d = fifo_data[7:2];
                    len_err_d   = {1'b0, fifo_data[7:2]} > MAX_LEN_W;
                    state_d     = (fifo_data[7:2] == 6'd0) ? ST_PARITY : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    acc_d       = acc_q ^ fifo_data;
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    cap_eop     = 1'b1;
                    cap_err     = (fifo_data != acc_q) | len_err_q;
                    acc_d       = 8'h00;
                    remaining_d = 6'd0;
                    len_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            remaining_q  <= 6'd0;
            acc_q        <= 8'h00;
            len_err_q    <= 1'b0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= fifo_read_enb;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            len_err_q   <= len_err_d;
            // A capture can only happen when the output register is already
            // free, so it never overwrites a byte that has not been taken.
            if (pending_q) begin
                dout_q       <= fifo_data;
                dout_valid_q <= 1'b1;
                dout_sop_q   <= cap_sop;
                dout_eop_q   <= cap_eop;
                dout_err_q   <= cap_err;
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
                dout_sop_q   <= 1'b0;
                dout_eop_q   <= 1'b0;
                dout_err_q   <= 1'b0;
            end
        end
    end

`ifdef ROUTER_PKT_READER_ERR_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt <= 8'h00;
        end else if (dout_valid_q && dout_ready && dout_eop_q && dout_err_q
                     && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sop   = dout_sop_q;
    assign dout_eop   = dout_eop_q;
    assign dout_err   = dout_err_q;
    assign busy       = (state_q != ST_IDLE) | pending_q | dout_valid_q;

endmodule
